// File: rtl/move_sequencer.sv
// Connect4 move sequencer: accepts a column request, validates it against per-column heights,
// writes the piece, runs the win-check handshake and updates turn / game status.
module move_sequencer #(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int COL_W = 3,
    parameter int ROW_W = 3,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drop_req,
    input  logic [COL_W-1:0] drop_col,
    output logic             drop_ack,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic             wr_player,
    output logic             chk_start,
    input  logic             chk_done,
    input  logic             chk_win,
    output logic             invalid_move,
    output logic             player_turn,
    output logic [1:0]       game_status,
    output logic             winner,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, VALIDATE, REJECT, WRITE, CHECK, OVER} state_t;

    localparam logic [1:0] ST_PLAY = 2'b00;
    localparam logic [1:0] ST_WIN  = 2'b01;
    localparam logic [1:0] ST_TIE  = 2'b10;

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] height [COLS];
    logic [ROW_W-1:0] height_nxt [COLS];
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       phase, phase_nxt;
    logic             turn_nxt, winner_nxt, ack_nxt, wr_en_nxt, chk_start_nxt, invalid_nxt;
    logic [1:0]       status_nxt;
    logic [ROW_W-1:0] wr_row_nxt;
    logic [COL_W-1:0] wr_col_nxt;
    logic             wr_player_nxt;
    logic             col_ok;

    assign col_ok = (col < COL_W'(COLS));
    assign busy   = (state != IDLE) && (state != OVER);

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        height_nxt    = height;
        cnt_nxt       = cnt;
        phase_nxt     = phase;
        turn_nxt      = player_turn;
        winner_nxt    = winner;
        status_nxt    = game_status;
        ack_nxt       = 1'b0;
        wr_en_nxt     = 1'b0;
        chk_start_nxt = 1'b0;
        invalid_nxt   = 1'b0;
        wr_row_nxt    = wr_row;
        wr_col_nxt    = wr_col;
        wr_player_nxt = wr_player;
        case (state)
            IDLE: begin
                if (drop_req) begin
                    col_nxt   = drop_col;
                    ack_nxt   = 1'b1;
                    state_nxt = VALIDATE;
                end
            end
            VALIDATE: begin
                if (!col_ok || height[col] == ROW_W'(ROWS))
                    state_nxt = REJECT;
                else
                    state_nxt = WRITE;
            end
            REJECT: begin
                invalid_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            WRITE: begin
                wr_en_nxt       = 1'b1;
                wr_row_nxt      = height[col];
                wr_col_nxt      = col;
                wr_player_nxt   = player_turn;
                height_nxt[col] = height[col] + ROW_W'(1);
                cnt_nxt         = cnt + CNT_W'(1);
                phase_nxt       = 2'd0;
                state_nxt       = CHECK;
            end
            CHECK: begin
                // phase 0 issues chk_start, phase 1 skips the start cycle's chk_done
                case (phase)
                    2'd0: begin
                        chk_start_nxt = 1'b1;
                        phase_nxt     = 2'd1;
                    end
                    2'd1: phase_nxt = 2'd2;
                    default: begin
                        if (chk_done) begin
                            if (chk_win) begin
                                status_nxt = ST_WIN;
                                winner_nxt = player_turn;
                                state_nxt  = OVER;
                            end else if (cnt == CNT_W'(ROWS * COLS)) begin
                                status_nxt = ST_TIE;
                                state_nxt  = OVER;
                            end else begin
                                turn_nxt  = ~player_turn;
                                state_nxt = IDLE;
                            end
                        end
                    end
                endcase
            end
            OVER: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            height       <= '{default: '0};
            cnt          <= '0;
            phase        <= 2'd0;
            player_turn  <= 1'b0;
            winner       <= 1'b0;
            game_status  <= ST_PLAY;
            drop_ack     <= 1'b0;
            wr_en        <= 1'b0;
            chk_start    <= 1'b0;
            invalid_move <= 1'b0;
        end else begin
            state        <= state_nxt;
            height       <= height_nxt;
            cnt          <= cnt_nxt;
            phase        <= phase_nxt;
            player_turn  <= turn_nxt;
            winner       <= winner_nxt;
            game_status  <= status_nxt;
            drop_ack     <= ack_nxt;
            wr_en        <= wr_en_nxt;
            chk_start    <= chk_start_nxt;
            invalid_move <= invalid_nxt;
        end
    end

    // Latched column and write-port payload carry no reset; they are qualified by strobes.
    always_ff @(posedge clk) begin
        col       <= col_nxt;
        wr_row    <= wr_row_nxt;
        wr_col    <= wr_col_nxt;
        wr_player <= wr_player_nxt;
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a board-level model predicts writes, rejects and
// turn/status changes; a monitor pops expected board events as the DUT strobes them.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       drop_req = 1'b0;
    logic [2:0] drop_col = 3'd0;
    logic       drop_ack, wr_en, wr_player, chk_start, invalid_move, player_turn, winner, busy;
    logic [2:0] wr_row, wr_col;
    logic       chk_done = 1'b0;
    logic       chk_win = 1'b0;
    logic [1:0] game_status;

    move_sequencer #(.COLS(7), .ROWS(6), .COL_W(3), .ROW_W(3), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .drop_req(drop_req), .drop_col(drop_col),
        .drop_ack(drop_ack), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_player(wr_player), .chk_start(chk_start), .chk_done(chk_done),
        .chk_win(chk_win), .invalid_move(invalid_move), .player_turn(player_turn),
        .game_status(game_status), .winner(winner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_wr;
        int row;
        int col;
        int player;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    // reference model: column fill levels, move count, whose turn, game result
    int  h[8];
    int  moves;
    int  turn;
    int  status;
    int  win_who;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) h[i] = 0;
        moves = 0; turn = 0; status = 0; win_who = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; drop_req = 1'b0; chk_done = 1'b0; chk_win = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (reset && (wr_en || invalid_move)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind", int'(wr_en), int'(e.is_wr));
                if (e.is_wr && wr_en) begin
                    check("wr_row", int'(wr_row), e.row);
                    check("wr_col", int'(wr_col), e.col);
                    check("wr_player", int'(wr_player), e.player);
                end
            end
        end
    end

    // Issues a request and follows it to cycle T+3 (valid) or T+3 after reject.
    task automatic start_move(input int col, output bit valid);
        ev_t e;
        bit  got;
        valid = (col < 7) && (h[col] < 6);
        e.is_wr = valid; e.row = valid ? h[col] : 0; e.col = col; e.player = turn;
        exp_q.push_back(e);
        drop_req = 1'b1;
        drop_col = 3'(col);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (drop_ack) begin got = 1'b1; break; end
        end
        drop_req = 1'b0;
        check("ack_seen", int'(got), 1);
        if (!got) begin
            void'(exp_q.pop_back());
            valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        check("ack_one_cycle", int'(drop_ack), 0);
        @(posedge clk); #1;
        if (valid) begin
            check("wr_en_at_t2", int'(wr_en), 1);
            h[col]++;
            moves++;
            @(posedge clk); #1;
            check("chk_start_at_t3", int'(chk_start), 1);
        end else begin
            check("invalid_at_t2", int'(invalid_move), 1);
            check("no_wr_on_reject", int'(wr_en), 0);
            @(posedge clk); #1;
            check("turn_after_reject", int'(player_turn), turn);
            check("status_after_reject", int'(game_status), status);
        end
    endtask

    task automatic finish_move(input bit win, input int lat);
        repeat (lat) begin
            @(posedge clk); #1;
            check("chk_start_single", int'(chk_start), 0);
        end
        @(posedge clk); #1;
        chk_done = 1'b1; chk_win = win;
        @(posedge clk); #1;
        chk_done = 1'b0; chk_win = 1'b0;
        if (win) begin
            status = 1; win_who = turn;
        end else if (moves == 42) begin
            status = 2;
        end else begin
            turn ^= 1;
        end
        check("turn_after_check", int'(player_turn), turn);
        check("status_after_check", int'(game_status), status);
        if (status == 1) check("winner", int'(winner), win_who);
        check("busy_after_check", int'(busy), 0);
    endtask

    task automatic do_move(input int col, input bit win, input int lat);
        bit v;
        start_move(col, v);
        if (v) finish_move(win, lat);
    endtask

    task automatic check_no_ack(input int cycles);
        int acks;
        acks = 0;
        drop_req = 1'b1;
        drop_col = 3'd2;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (drop_ack) acks++;
        end
        drop_req = 1'b0;
        check("no_ack_when_over", acks, 0);
        check("status_holds_over", int'(game_status), status);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v;
        model_reset();
        do_reset();
        @(posedge clk); #1;
        check("rst_status", int'(game_status), 0);
        check("rst_turn", int'(player_turn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(drop_ack), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_chk_start", int'(chk_start), 0);
        check("rst_invalid", int'(invalid_move), 0);

        // first move into column 3
        do_move(3, 1'b0, 0);

        // fill column 0, then overflow it; then out-of-range column
        do_reset();
        for (int i = 0; i < 6; i++) do_move(0, 1'b0, i % 3);
        do_move(0, 1'b0, 0);
        do_move(7, 1'b0, 0);
        do_move(1, 1'b0, 0);

        // P2 wins, then requests are ignored
        do_reset();
        do_move(4, 1'b0, 0);
        do_move(5, 1'b1, 1);
        check_no_ack(10);

        // full board: tie, then win on the final cell
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++)
                    do_move(c, (pass == 1) && (c == 6) && (r == 5), 0);
            check_no_ack(3);
        end

        // reset during CHECK aborts the move
        do_reset();
        do_move(3, 1'b0, 0);
        do_move(3, 1'b0, 0);
        do_move(2, 1'b0, 0);
        start_move(6, v);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_status", int'(game_status), 0);
        check("mid_rst_turn", int'(player_turn), 0);
        reset = 1'b1;
        model_reset();
        do_move(3, 1'b0, 0);

        // random games
        for (int g = 0; g < 4; g++) begin
            do_reset();
            for (int m = 0; m < 70 && status == 0; m++)
                do_move($urandom_range(0, 7), $urandom_range(0, 29) == 0, $urandom_range(0, 2));
            if (status != 0) check_no_ack(3);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
